// File: rtl/seq_mag_comparator_if.sv
// seq_mag_comparator_if: operand, cascade and start/busy/done bundle for the digit-serial comparator
interface seq_mag_comparator_if #(parameter int WIDTH = 16);
   logic start, signed_mode, g_in, e_in, l_in;
   logic busy, done, g_out, e_out, l_out;
   logic [WIDTH-1:0] a, b;
   modport master(output start, signed_mode, a, b, g_in, e_in, l_in,
                  input busy, done, g_out, e_out, l_out);
   modport slave(input start, signed_mode, a, b, g_in, e_in, l_in,
                 output busy, done, g_out, e_out, l_out);
endinterface

// File: rtl/seq_mag_comparator.sv
// seq_mag_comparator: MSB-first digit-serial magnitude comparator with 74x85-style cascade
module seq_mag_comparator #(
   parameter int WIDTH      = 16,
   parameter int DIGIT      = 4,
   parameter int EARLY_EXIT = 1
) (
   input logic clk,
   input logic rst,
   seq_mag_comparator_if.slave bus
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
   localparam logic [0:0] IDLE = 1'b0, RUN = 1'b1;
   logic [0:0] state;
   logic [IW-1:0] idx;
   logic [WIDTH-1:0] ra, rb;
   logic rs, rg, re, rl, found, dir_gt, done, g, e, l;
   logic [DIGIT-1:0] flip, da, db;
   logic neq, gt, hit, hgt, finish;
   // Inverting the sign bit maps two's complement onto unsigned order
   always_comb begin
      flip = '0;
      flip[DIGIT-1] = rs && idx == IW'(NDIG - 1);
      da = ra[idx*DIGIT +: DIGIT] ^ flip;
      db = rb[idx*DIGIT +: DIGIT] ^ flip;
      neq = da != db;
      gt = da > db;
      hit = found || neq;
      hgt = found ? dir_gt : gt;
      finish = (EARLY_EXIT != 0 && neq) || idx == '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         done <= 1'b0;
         found <= 1'b0;
         {g, e, l} <= 3'b000;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (bus.start) begin
               ra <= bus.a;
               rb <= bus.b;
               rs <= bus.signed_mode;
               {rg, re, rl} <= {bus.g_in, bus.e_in, bus.l_in};
               idx <= IW'(NDIG - 1);
               found <= 1'b0;
               state <= RUN;
            end
         end else if (finish) begin
            g <= hit ? hgt : ~re & ~rl;
            e <= ~hit & re;
            l <= hit ? ~hgt : ~re & ~rg;
            done <= 1'b1;
            state <= IDLE;
         end else begin
            idx <= idx - IW'(1);
            if (neq && !found) begin
               found <= 1'b1;
               dir_gt <= gt;
            end
         end
      end
   end
   assign bus.busy = state == RUN;
   assign bus.done = done;
   assign bus.g_out = g;
   assign bus.e_out = e;
   assign bus.l_out = l;
endmodule

// File: tb/tb_seq_mag_comparator.sv
// tb_seq_mag_comparator: vector table, corner sequences and random compares on early-exit and full-latency instances
module tb_seq_mag_comparator;
   logic clk = 1'b0, rst = 1'b1;
   int checks = 0, failures = 0;
   seq_mag_comparator_if #(.WIDTH(16)) bi1 ();
   seq_mag_comparator_if #(.WIDTH(16)) bi0 ();
   seq_mag_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1)) u1 (.clk(clk), .rst(rst), .bus(bi1.slave));
   seq_mag_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(0)) u0 (.clk(clk), .rst(rst), .bus(bi0.slave));
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a, b;
      logic sm, gi, ei, li;
      logic [2:0] res;
      int m1, m0;
   } vec_t;
   vec_t tbl[11];

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", nm, got, exp);
      end
   endtask

   function automatic vec_t model(input logic [15:0] a, b, input logic sm, gi, ei, li);
      vec_t v;
      int ia, ib;
      v.a = a; v.b = b; v.sm = sm; v.gi = gi; v.ei = ei; v.li = li;
      ia = int'(a);
      ib = int'(b);
      if (sm && a[15]) ia -= 65536;
      if (sm && b[15]) ib -= 65536;
      v.res = ia > ib ? 3'b100 : ia < ib ? 3'b001 : ei ? 3'b010 :
              (gi && !li) ? 3'b100 : (li && !gi) ? 3'b001 : gi ? 3'b000 : 3'b101;
      v.m0 = 4;
      v.m1 = 4;
      for (int i = 0; i < 16; i++) if (a[i] != b[i]) v.m1 = 4 - i / 4;
      return v;
   endfunction

   task automatic set_in(input vec_t v);
      bi1.a = v.a; bi1.b = v.b; bi1.signed_mode = v.sm;
      bi1.g_in = v.gi; bi1.e_in = v.ei; bi1.l_in = v.li;
      bi0.a = v.a; bi0.b = v.b; bi0.signed_mode = v.sm;
      bi0.g_in = v.gi; bi0.e_in = v.ei; bi0.l_in = v.li;
   endtask

   // chg: re-pulse start while busy and alter operand A mid-compare
   task automatic run_cmp(input vec_t v, input string nm, input bit chg);
      int p1, p0, m1, m0;
      logic [2:0] r1, r0;
      p1 = 0; p0 = 0; m1 = 0; m0 = 0; r1 = 3'b000; r0 = 3'b000;
      set_in(v);
      bi1.start = 1'b1; bi0.start = 1'b1;
      @(posedge clk); #1;
      bi1.start = 1'b0; bi0.start = 1'b0;
      chk({nm, "_busy"}, int'({bi1.busy, bi0.busy}), 3);
      for (int n = 1; n <= 6; n++) begin
         if (chg && n == 2) begin
            bi1.start = 1'b1; bi0.start = 1'b1;
            bi1.a = ~v.a; bi0.a = ~v.a;
         end
         if (chg && n == 3) begin
            bi1.start = 1'b0; bi0.start = 1'b0;
         end
         @(posedge clk); #1;
         if (bi1.done) begin
            p1++;
            if (p1 == 1) begin m1 = n; r1 = {bi1.g_out, bi1.e_out, bi1.l_out}; end
         end
         if (bi0.done) begin
            p0++;
            if (p0 == 1) begin m0 = n; r0 = {bi0.g_out, bi0.e_out, bi0.l_out}; end
         end
      end
      chk({nm, "_pulses_ee1"}, p1, 1);
      chk({nm, "_lat_ee1"}, m1, v.m1);
      chk({nm, "_res_ee1"}, int'(r1), int'(v.res));
      chk({nm, "_pulses_ee0"}, p0, 1);
      chk({nm, "_lat_ee0"}, m0, v.m0);
      chk({nm, "_res_ee0"}, int'(r0), int'(v.res));
   endtask

   initial begin
      int dn;
      vec_t v;
      logic [15:0] ra, rb;
      tbl[0]  = '{16'h8000, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 1, 4};
      tbl[1]  = '{16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 1, 4};
      tbl[2]  = '{16'h0101, 16'h0101, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 4, 4};
      tbl[3]  = '{16'h0101, 16'h0101, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 4, 4};
      tbl[4]  = '{16'h0101, 16'h0101, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 4, 4};
      tbl[5]  = '{16'h0101, 16'h0101, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 4, 4};
      tbl[6]  = '{16'h1234, 16'h1235, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 4, 4};
      tbl[7]  = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 1, 4};
      tbl[8]  = '{16'h7FFF, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0, 3'b100, 1, 4};
      tbl[9]  = '{16'h00F0, 16'h00E0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 3, 4};
      tbl[10] = '{16'h1000, 16'h2000, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 1, 4};
      bi1.start = 1'b0; bi0.start = 1'b0;
      set_in(tbl[0]);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", int'({bi1.busy, bi1.done, bi1.g_out, bi1.e_out, bi1.l_out,
                               bi0.busy, bi0.done, bi0.g_out, bi0.e_out, bi0.l_out}), 0);
      rst = 1'b0;
      foreach (tbl[i]) run_cmp(tbl[i], $sformatf("vec%0d", i), 1'b0);
      run_cmp(tbl[6], "midrun", 1'b1);

      set_in(tbl[6]);
      bi1.start = 1'b1; bi0.start = 1'b1;
      @(posedge clk); #1;
      bi1.start = 1'b0; bi0.start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_state", int'({bi1.busy, bi1.done, bi1.g_out, bi1.e_out, bi1.l_out,
                               bi0.busy, bi0.done, bi0.g_out, bi0.e_out, bi0.l_out}), 0);
      dn = 0;
      repeat (5) begin
         @(posedge clk); #1;
         dn += int'(bi1.done) + int'(bi0.done);
      end
      chk("abort_no_done", dn, 0);
      run_cmp(tbl[6], "after_abort", 1'b0);

      set_in(tbl[0]);
      bi1.start = 1'b1;
      @(posedge clk); #1;
      bi1.start = 1'b0;
      @(posedge clk); #1;
      chk("b2b_first", int'({bi1.done, bi1.g_out, bi1.e_out, bi1.l_out}), 4'b1100);
      bi1.a = 16'h0000; bi1.b = 16'h0001; bi1.start = 1'b1;
      @(posedge clk); #1;
      bi1.start = 1'b0;
      chk("b2b_accept", int'({bi1.busy, bi1.done, bi1.g_out, bi1.e_out, bi1.l_out}), 5'b10100);
      dn = 0;
      repeat (3) begin
         @(posedge clk); #1;
         dn += int'(bi1.done);
      end
      chk("b2b_hold", int'({bi1.g_out, bi1.e_out, bi1.l_out}), 3'b100);
      @(posedge clk); #1;
      chk("b2b_second", int'({dn[1:0], bi1.done, bi1.busy, bi1.g_out, bi1.e_out, bi1.l_out}), 7'b0010001);

      for (int i = 0; i < 40; i++) begin
         ra = 16'($urandom);
         case ($urandom_range(0, 3))
            0: rb = ra;
            1: rb = ra ^ (16'h1 << $urandom_range(0, 15));
            default: rb = 16'($urandom);
         endcase
         v = model(ra, rb, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         run_cmp(v, $sformatf("rnd%0d", i), 1'b0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
